key_expansion: RTL



---
 rtl/key_expansion_if.sv | 20 ++
 rtl/key_expansion.sv | 126 ++++++++++++
 2 files changed

// File: rtl/key_expansion_if.sv
// Handshake and round-key bus between a key source / round-key store and key_expansion.
interface key_expansion_if;
   logic [127:0] key_in;
   logic         key_valid;
   logic         key_ready;
   logic         rk_valid;
   logic [3:0]   rk_index;
   logic [127:0] rk_out;
   logic         done;

   modport master (
      output key_in, key_valid,
      input  key_ready, rk_valid, rk_index, rk_out, done
   );

   modport slave (
      input  key_in, key_valid,
      output key_ready, rk_valid, rk_index, rk_out, done
   );
endinterface

// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: one round key per cycle, rounds 0..10,
// with the combinational AES S-box used for SubWord.

module sbox (
   input  logic [7:0] a,
   output logic [7:0] s
);
   function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = x;
      for (int i = 0; i < 8; i++) begin
         if (y[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] x2, x3, x6, x12, x14, x15, x30, x60, x120, x240, inv;

   // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
   always_comb begin
      x2   = gf_mul(a, a);
      x3   = gf_mul(x2, a);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x14  = gf_mul(x12, x2);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      inv  = gf_mul(x240, x14);
      s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   end
endmodule

// state  | meaning
// IDLE   | key_ready high, W cleared, waiting for a key
// EXPAND | emitting round key rk_index each cycle, 0..10
module key_expansion (
   input  logic             clk,
   input  logic             rst,
   key_expansion_if.slave   kif
);
   typedef enum logic {IDLE, EXPAND} state_t;

   state_t       state;
   logic [127:0] w;
   logic [7:0]   rcon;
   logic [3:0]   cnt;
   logic         key_ready_q;
   logic         rk_valid_q;
   logic         done_q;

   logic [31:0]  w3_rot;
   logic [31:0]  sub;
   logic [31:0]  temp;
   logic [31:0]  n0, n1, n2, n3;
   logic [7:0]   rcon_next;

   assign w3_rot = {w[23:0], w[31:24]};

   for (genvar b = 0; b < 4; b++) begin : g_sub
      sbox u_sbox (.a(w3_rot[8*b +: 8]), .s(sub[8*b +: 8]));
   end

   assign temp      = sub ^ {rcon, 24'h000000};
   assign n0        = w[127:96] ^ temp;
   assign n1        = n0 ^ w[95:64];
   assign n2        = n1 ^ w[63:32];
   assign n3        = n2 ^ w[31:0];
   assign rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         w           <= '0;
         rcon        <= 8'h00;
         cnt         <= 4'd0;
         key_ready_q <= 1'b1;
         rk_valid_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (kif.key_valid) begin
                  state       <= EXPAND;
                  w           <= kif.key_in;
                  rcon        <= 8'h01;
                  cnt         <= 4'd0;
                  key_ready_q <= 1'b0;
                  rk_valid_q  <= 1'b1;
                  done_q      <= 1'b0;
               end
            end
            EXPAND: begin
               if (cnt < 4'd10) begin
                  w      <= {n0, n1, n2, n3};
                  rcon   <= rcon_next;
                  cnt    <= cnt + 4'd1;
                  // done must coincide with round 10, so it is set on the edge that loads it.
                  done_q <= (cnt == 4'd9);
               end else begin
                  state       <= IDLE;
                  w           <= '0;
                  rcon        <= 8'h00;
                  cnt         <= 4'd0;
                  key_ready_q <= 1'b1;
                  rk_valid_q  <= 1'b0;
                  done_q      <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign kif.key_ready = key_ready_q;
   assign kif.rk_valid  = rk_valid_q;
   assign kif.rk_index  = cnt;
   assign kif.rk_out    = w;
   assign kif.done      = done_q;
endmodule
